// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter for the register file's single write
// port (WE3/A3/WD3). Requester 0 is ALU writeback and requester 1 is load
// writeback. A lock mode gives one requester back-to-back grants, and writes
// aimed at the PC address (2**N-1) are accepted but then dropped.
// Optional feature macro: RF_BYPASS_EN adds the same-cycle read bypass ports.
module regfile_write_arbiter #(
    parameter int N = 4,
    parameter int M = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req0_lock,
    input  logic [N-1:0]     req0_addr,
    input  logic [M-1:0]     req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic             req1_lock,
    input  logic [N-1:0]     req1_addr,
    input  logic [M-1:0]     req1_data,
    output logic             req1_ready,
    output logic             WE3,
    output logic [N-1:0]     A3,
    output logic [M-1:0]     WD3,
    output logic [2**N-1:0]  pending_mask,
    output logic             illegal_wr,
`ifdef RF_BYPASS_EN
    input  logic [N-1:0]     rd_a1,
    input  logic [N-1:0]     rd_a2,
    output logic             byp1,
    output logic             byp2,
    output logic [M-1:0]     byp_data,
`endif
    output logic             last_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic [N-1:0] PC_ADDR = {N{1'b1}};

    state_t         state_r;
    logic           rdy0_s;
    logic           rdy1_s;
    logic           xfer0_s;
    logic           xfer1_s;
    logic           xfer_s;
    logic [N-1:0]   sel_addr_s;
    logic [M-1:0]   sel_data_s;
    logic           sel_lock_s;

    // Ready generation: depends only on state, last grant and the valids.
    always_comb begin
        rdy0_s = 1'b0;
        rdy1_s = 1'b0;
        if (reset) begin
            rdy0_s = 1'b0;
            rdy1_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req0_valid && req1_valid) begin
                        if (last_grant == 1'b1) begin
                            rdy0_s = 1'b1;
                        end else begin
                            rdy1_s = 1'b1;
                        end
                    end else begin
                        rdy0_s = req0_valid;
                        rdy1_s = req1_valid;
                    end
                end
                LOCK0: rdy0_s = req0_valid;
                LOCK1: rdy1_s = req1_valid;
                default: begin
                    rdy0_s = 1'b0;
                    rdy1_s = 1'b0;
                end
            endcase
        end
    end

    assign req0_ready = rdy0_s;
    assign req1_ready = rdy1_s;
    assign xfer0_s    = req0_valid && rdy0_s;
    assign xfer1_s    = req1_valid && rdy1_s;
    assign xfer_s     = xfer0_s || xfer1_s;

    // Mux the granted requester's payload onto the write path.
    always_comb begin
        sel_addr_s = req0_addr;
        sel_data_s = req0_data;
        sel_lock_s = req0_lock;
        if (xfer1_s) begin
            sel_addr_s = req1_addr;
            sel_data_s = req1_data;
            sel_lock_s = req1_lock;
        end else begin
            sel_addr_s = req0_addr;
            sel_data_s = req0_data;
            sel_lock_s = req0_lock;
        end
    end

    // Arbitration FSM plus registered write-port and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            WE3        <= 1'b0;
            A3         <= {N{1'b0}};
            WD3        <= {M{1'b0}};
            illegal_wr <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (xfer_s) begin
                last_grant <= xfer1_s;
                if (sel_addr_s == PC_ADDR) begin
                    // PC is loaded elsewhere: drop the write, keep A3/WD3.
                    WE3        <= 1'b0;
                    illegal_wr <= 1'b1;
                end else begin
                    WE3        <= 1'b1;
                    A3         <= sel_addr_s;
                    WD3        <= sel_data_s;
                    illegal_wr <= 1'b0;
                end
            end else begin
                WE3        <= 1'b0;
                illegal_wr <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (xfer_s && sel_lock_s) begin
                        state_r <= xfer1_s ? LOCK1 : LOCK0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOCK0: begin
                    if (xfer0_s && !req0_lock) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= LOCK0;
                    end
                end
                LOCK1: begin
                    if (xfer1_s && !req1_lock) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= LOCK1;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // One-hot of the in-flight write address for read-side stall logic.
    always_comb begin
        pending_mask = {(2**N){1'b0}};
        if (WE3) begin
            pending_mask[A3] = 1'b1;
        end else begin
            pending_mask = {(2**N){1'b0}};
        end
    end

`ifdef RF_BYPASS_EN
    assign byp1     = WE3 && (A3 == rd_a1);
    assign byp2     = WE3 && (A3 == rd_a2);
    assign byp_data = WD3;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_lock, req1_valid, req1_lock;
    logic [3:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        WE3, illegal_wr, last_grant;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [15:0] pending_mask;
`ifdef RF_BYPASS_EN
    logic [3:0]  rd_a1 = 4'd0, rd_a2 = 4'd0;
    logic        byp1, byp2;
    logic [31:0] byp_data;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic        m_we, m_ill;
    logic [3:0]  m_a3;
    logic [31:0] m_wd;
    int          m_last;
    int          m_lock;   // -1 = no lock, else locked requester index

    regfile_write_arbiter #(.N(4), .M(32)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_lock(req0_lock), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_lock(req1_lock), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .WE3(WE3), .A3(A3), .WD3(WD3), .pending_mask(pending_mask),
        .illegal_wr(illegal_wr),
`ifdef RF_BYPASS_EN
        .rd_a1(rd_a1), .rd_a2(rd_a2), .byp1(byp1), .byp2(byp2), .byp_data(byp_data),
`endif
        .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, check readies vs model, advance model, check outputs.
    task automatic cycle(input logic rst,
                         input logic v0, input logic l0, input logic [3:0] a0, input logic [31:0] d0,
                         input logic v1, input logic l1, input logic [3:0] a1, input logic [31:0] d1,
                         output int gnt);
        logic e0, e1;
        int   mg;
        logic [15:0] one;
        one = 16'h0001;
        reset = rst;
        req0_valid = v0; req0_lock = l0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_lock = l1; req1_addr = a1; req1_data = d1;
        #1;
        e0 = 1'b0; e1 = 1'b0;
        if (!rst) begin
            if (m_lock == 0)      e0 = v0;
            else if (m_lock == 1) e1 = v1;
            else if (v0 && v1) begin
                if (m_last == 1) e0 = 1'b1; else e1 = 1'b1;
            end else begin
                e0 = v0; e1 = v1;
            end
        end
        chk("req0_ready", req0_ready, e0);
        chk("req1_ready", req1_ready, e1);
        gnt = (req0_valid && req0_ready) ? 0 : ((req1_valid && req1_ready) ? 1 : -1);
        mg  = e0 ? 0 : (e1 ? 1 : -1);
        if (rst) begin
            m_we = 1'b0; m_ill = 1'b0; m_a3 = 4'd0; m_wd = 32'd0; m_last = 1; m_lock = -1;
        end else if (mg >= 0) begin
            m_last = mg;
            if (((mg == 0) ? a0 : a1) == 4'd15) begin
                m_we = 1'b0; m_ill = 1'b1;
            end else begin
                m_we = 1'b1; m_ill = 1'b0;
                m_a3 = (mg == 0) ? a0 : a1;
                m_wd = (mg == 0) ? d0 : d1;
            end
            if (m_lock == -1 && ((mg == 0) ? l0 : l1)) m_lock = mg;
            else if (m_lock == mg && !((mg == 0) ? l0 : l1)) m_lock = -1;
        end else begin
            m_we = 1'b0; m_ill = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("WE3", WE3, m_we);
        chk("illegal_wr", illegal_wr, m_ill);
        chk("last_grant", last_grant, m_last[0]);
        chk("A3", A3, m_a3);
        chk("WD3", WD3, m_wd);
        chk("pending_mask", pending_mask, m_we ? (one << m_a3) : 16'h0000);
    endtask

    initial begin
        int g;
        reset = 1'b1;
        req0_valid = 1'b0; req0_lock = 1'b0; req0_addr = 4'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_lock = 1'b0; req1_addr = 4'd0; req1_data = 32'd0;
        m_we = 1'b0; m_ill = 1'b0; m_a3 = 4'd0; m_wd = 32'd0; m_last = 1; m_lock = -1;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, g);
        cycle(1'b1, 1'b1, 1'b0, 4'd1, 32'd5, 1'b1, 1'b0, 4'd2, 32'd6, g);
        chk("rst_gnt", g, -1);
        chk("rst_we", WE3, 1'b0);
        chk("rst_last", last_grant, 1'b1);
        chk("rst_pm", pending_mask, 16'h0000);

        // Single requester write, latency one cycle
        cycle(1'b0, 1'b1, 1'b0, 4'd3, 32'hAAAA0001, 1'b0, 1'b0, 4'd0, 32'd0, g);
        chk("t1_gnt", g, 0);
        chk("t1_we", WE3, 1'b1);
        chk("t1_a3", A3, 4'd3);
        chk("t1_wd", WD3, 32'hAAAA0001);
        chk("t1_pm", pending_mask, 16'h0008);

        // Round robin alternation from reset
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0, 4'd0, 32'd0, g);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'd1, 32'(i), 1'b1, 1'b0, 4'd2, 32'(100 + i), g);
            chk("rr_gnt", g, i % 2);
            chk("rr_a3", A3, (i % 2 == 1) ? 4'd2 : 4'd1);
            chk("rr_we", WE3, 1'b1);
        end

        // Lock by requester 1 (make last_grant=0 first)
        cycle(1'b0, 1'b1, 1'b0, 4'd8, 32'd8, 1'b0, 1'b0, 4'd0, 32'd0, g);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'd10, 32'd10, 1'b1, (i < 2), 4'(4 + i), 32'(40 + i), g);
            chk("lk_gnt", g, 1);
            chk("lk_a3", A3, 4'(4 + i));
        end
        cycle(1'b0, 1'b1, 1'b0, 4'd10, 32'd10, 1'b1, 1'b0, 4'd11, 32'd11, g);
        chk("lk_release_gnt", g, 0);

        // PC write dropped, but consumes the round-robin turn
        cycle(1'b0, 1'b1, 1'b0, 4'd15, 32'h1234, 1'b0, 1'b0, 4'd0, 32'd0, g);
        chk("pc_gnt", g, 0);
        chk("pc_we", WE3, 1'b0);
        chk("pc_ill", illegal_wr, 1'b1);
        chk("pc_a3_hold", A3, 4'd10);
        cycle(1'b0, 1'b1, 1'b0, 4'd2, 32'd2, 1'b1, 1'b0, 4'd3, 32'd3, g);
        chk("pc_next_gnt", g, 1);
        chk("pc_ill_pulse", illegal_wr, 1'b0);

        // Same address from both: winner then loser
        cycle(1'b0, 1'b1, 1'b0, 4'd7, 32'h11, 1'b1, 1'b0, 4'd7, 32'h22, g);
        chk("sa_gnt0", g, 0);
        chk("sa_wd0", WD3, 32'h11);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd7, 32'h22, g);
        chk("sa_gnt1", g, 1);
        chk("sa_wd1", WD3, 32'h22);
        chk("sa_a3", A3, 4'd7);

        // Reset during LOCK0 cancels the in-flight write and the lock
        cycle(1'b0, 1'b1, 1'b1, 4'd9, 32'd9, 1'b0, 1'b0, 4'd0, 32'd0, g);
        chk("rl_gnt", g, 0);
        chk("rl_we", WE3, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 4'd12, 32'd12, 1'b1, 1'b0, 4'd13, 32'd13, g);
        chk("rl_rst_gnt", g, -1);
        chk("rl_rst_we", WE3, 1'b0);
        chk("rl_rst_last", last_grant, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 4'd1, 32'd1, 1'b1, 1'b0, 4'd2, 32'd2, g);
        chk("rl_post_gnt", g, 0);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0, 4'd2, 32'd2, g);
        chk("rl_unlocked_gnt", g, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 49) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  4'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  4'($urandom_range(0, 15)), $urandom, g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Arbitrates the register file's single write port (WE3/A3/WD3) between two writeback requesters: req0 = ALU writeback, req1 = load/memory writeback.
- Uses valid/ready handshakes and round-robin fairness.
- Supports a lock mode that gives one requester back-to-back grants for multi-register loads.
- Rejects writes to the PC register (highest address), because the PC is loaded through its own dedicated path.

Parameters:
- N, 4, register address width (2**N registers; address 2**N-1 is the PC)
- M, 32, data width

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a write
- req0_lock  input  1  requester 0 wants the port held after this transfer
- req0_addr  input  N  destination register
- req0_data  input  M  write data
- req0_ready  output  1  requester 0 transfer accepted this cycle
- req1_valid, req1_lock, req1_addr, req1_data, req1_ready  same as req0, for requester 1
- WE3  output  1  registered write enable to the register file
- A3  output  N  registered write address
- WD3  output  M  registered write data
- pending_mask  output  2**N  one-hot of A3 when WE3=1, else 0
- illegal_wr  output  1  one-cycle pulse: a PC-address write was dropped
- last_grant  output  1  index of the most recently granted requester

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: WE3=0, A3=0, WD3=0, illegal_wr=0, pending_mask=0, last_grant=1, FSM=IDLE. Requester 0 therefore wins the first contested cycle.
- Transfer rule: a transfer happens when reqX_valid && reqX_ready.
  - readyX is combinational from the FSM state and all valid inputs.
  - At most one ready is high per cycle.
  - ready never depends on ready.
- FSM states and transitions:
  - IDLE: only one valid → that requester is ready. Both valid → the requester != last_grant is ready. On a transfer with lock=1, go to LOCK0 or LOCK1 (the granted one).
  - LOCK0: only requester 0 may be ready; req1_ready=0 even if req1 is valid. A requester-0 transfer with req0_lock=0 returns to IDLE. req0_valid=0 holds LOCK0 with no grant.
  - LOCK1: symmetric to LOCK0.
- last_grant updates on every transfer, including dropped illegal ones.
- Latency: a transfer in cycle T drives WE3=1 with A3=addr and WD3=data in cycle T+1, for exactly one cycle. No transfer in T → WE3=0 in T+1; A3/WD3 hold their previous values.
- Throughput: one write per cycle, with no bubbles between back-to-back transfers.
- Illegal address: a transfer with addr == 2**N-1 is accepted normally (ready=1, consumes its round-robin turn, obeys lock). It is then dropped: WE3=0 in T+1 and illegal_wr=1 in T+1.
- Same address from both requesters: the round-robin winner writes in T+1 and the loser in T+2. The final register value is the loser's data.
- Reset mid-operation:
  - The in-flight output write is cancelled: WE3=0 in the cycle after reset.
  - A lock is released and the FSM returns to IDLE.
  - Transfers presented during a reset cycle are not accepted: ready=0 while reset=1.
- pending_mask is derived combinationally from the registered WE3/A3. Read-side stall logic uses it.

Optional Feature:
- Macro: RF_BYPASS_EN.
- When defined, adds:
  - inputs rd_a1[N-1:0] and rd_a2[N-1:0]
  - outputs byp1, byp2 (1 bit each) and byp_data[M-1:0]
- bypX = WE3 && (A3 == rd_aX); byp_data = WD3. This forwards the in-flight write to same-cycle readers.
- When undefined, these ports do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then req0 only (addr=3, data=0xAAAA0001) → req0_ready=1 in T; T+1: WE3=1, A3=3, WD3=0xAAAA0001, pending_mask=0x0008.
- Both valid for 4 cycles (req0 addr=1, req1 addr=2) → grants alternate 0,1,0,1; A3 sequence 1,2,1,2; WE3 high for 4 consecutive cycles.
- req1 transfer with lock=1 (addrs 4,5,6), lock deasserted on addr 6, with req0 valid throughout → req0_ready=0 for 3 cycles; req0 is granted in the 4th cycle.
- req0 addr=15 (data 0x1234) → req0_ready=1; T+1: WE3=0, illegal_wr=1 for one cycle; next contested cycle grants req1.
- Both valid to addr=7 (req0 data=0x11, req1 data=0x22), last_grant=1 → T+1 writes 0x11, T+2 writes 0x22.
- reset asserted in the cycle after a req0 transfer while in LOCK0 → WE3=0 next cycle, FSM returns to IDLE; after reset a contested cycle grants req0 (last_grant=1).
